// File: rtl/vsdma_axi_pkg.sv
// Shared types and sizing helpers for the video-DMA AXI RAM responder.
// Widths depend on the instantiating module's data width, so they are exposed as functions.
package vsdma_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_ACK,
    ST_WRITE,
    ST_AR_ACK,
    ST_READ
  } state_t;

  // Address units are 32-bit words; this is the shift from address to beat index.
  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 32);
  endfunction

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_rd_skid_buf.sv
// Two-entry registered read output buffer: RAM data lands here one cycle after issue.
// in_rdy says a read issued this cycle can be absorbed next cycle; output holds under out_rdy low.
module axi_rd_skid_buf #(
  parameter int DATA_W = 256
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_last,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_last,
  input  logic              out_rdy
);

  logic [1:0]        cnt;
  logic [DATA_W-1:0] head_dat, tail_dat;
  logic              head_last, tail_last;
  logic              pop;

  assign pop      = (cnt != 2'd0) && out_rdy;
  assign out_vld  = (cnt != 2'd0);
  assign out_dat  = head_dat;
  assign out_last = head_last;
  // Occupancy after this cycle must leave room for data returning next cycle.
  assign in_rdy   = (({1'b0, cnt} + {2'b00, in_vld}) - {2'b00, pop}) < 3'd2;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cnt       <= 2'd0;
      head_dat  <= '0;
      tail_dat  <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
    end else begin
      cnt <= (cnt + {1'b0, in_vld}) - {1'b0, pop};
      if (pop) begin
        if (cnt == 2'd2) begin
          head_dat  <= tail_dat;
          head_last <= tail_last;
          if (in_vld) begin
            tail_dat  <= in_dat;
            tail_last <= in_last;
          end
        end else if (in_vld) begin
          head_dat  <= in_dat;
          head_last <= in_last;
        end
      end else if (in_vld) begin
        if (cnt == 2'd0) begin
          head_dat  <= in_dat;
          head_last <= in_last;
        end else begin
          tail_dat  <= in_dat;
          tail_last <= in_last;
        end
      end
    end
  end

endmodule

// File: rtl/vsdma_axi_ram_slave.sv
// AXI4 (AW/W/AR/R, no B) responder backed by a single-port RAM, one burst at a time.
// Reads: first RVALID two cycles after the AR handshake, then one beat per cycle under RREADY.
module vsdma_axi_ram_slave
  import vsdma_axi_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH   = 4,
  parameter int S_AXI_ADDR_WIDTH = 28,
  parameter int S_AXI_DATA_WIDTH = 256,
  parameter int MEM_DEPTH        = 1024
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_WID,
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          busy,
  output logic                          len_err,
  output logic [15:0]                   wr_burst_cnt,
  output logic [15:0]                   rd_burst_cnt
);

  localparam int SHIFT  = beat_shift(S_AXI_DATA_WIDTH);
  localparam int STRB_W = strb_width(S_AXI_DATA_WIDTH);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  function automatic logic [IDX_W-1:0] idx_of(input logic [S_AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> SHIFT);
  endfunction

  state_t state, state_nxt;
  logic   prio_wr, contest;
  logic   wr_hs, r_hs, rd_issue, skid_in_rdy;
  logic [IDX_W-1:0]            wr_idx, rd_idx, ram_addr;
  logic [7:0]                  wr_len, wr_cnt;
  logic [8:0]                  rd_left;
  logic                        rd_pend_vld, rd_pend_last;
  logic [S_AXI_DATA_WIDTH-1:0] rd_q;
  logic [S_AXI_ID_WIDTH-1:0]   awid_q;
  logic [S_AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                        unused_ok;

  assign unused_ok = &{1'b0, awid_q, S_AXI_WID};
  assign busy      = (state != ST_IDLE);
  assign wr_hs     = (state == ST_WRITE) && S_AXI_WVALID;
  assign r_hs      = S_AXI_RVALID && S_AXI_RREADY;
  assign rd_issue  = (state == ST_AR_ACK) ||
                     ((state == ST_READ) && (rd_left != 9'd0) && skid_in_rdy);

  always_comb begin
    state_nxt     = state;
    contest       = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    ram_addr      = rd_idx;
    case (state)
      ST_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_ARVALID) begin
          contest   = 1'b1;
          state_nxt = prio_wr ? ST_AW_ACK : ST_AR_ACK;
        end else if (S_AXI_AWVALID) begin
          state_nxt = ST_AW_ACK;
        end else if (S_AXI_ARVALID) begin
          state_nxt = ST_AR_ACK;
        end
      end
      ST_AW_ACK: begin
        S_AXI_AWREADY = 1'b1;
        state_nxt     = ST_WRITE;
      end
      ST_WRITE: begin
        S_AXI_WREADY = 1'b1;
        ram_addr     = wr_idx;
        if (wr_hs && (wr_cnt == wr_len)) state_nxt = ST_IDLE;
      end
      ST_AR_ACK: begin
        S_AXI_ARREADY = 1'b1;
        ram_addr      = idx_of(S_AXI_ARADDR);
        state_nxt     = ST_READ;
      end
      ST_READ: begin
        if (r_hs && S_AXI_RLAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read-first single-port RAM; contents survive reset.
  always_ff @(posedge S_AXI_ACLK) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_hs && S_AXI_WSTRB[b]) mem[ram_addr][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
    end
    rd_q <= mem[ram_addr];
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state        <= ST_IDLE;
      prio_wr      <= 1'b1;
      wr_idx       <= '0;
      wr_len       <= 8'd0;
      wr_cnt       <= 8'd0;
      rd_idx       <= '0;
      rd_left      <= 9'd0;
      rd_pend_vld  <= 1'b0;
      rd_pend_last <= 1'b0;
      awid_q       <= '0;
      S_AXI_RID    <= '0;
      len_err      <= 1'b0;
      wr_burst_cnt <= 16'd0;
      rd_burst_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (contest) prio_wr <= !prio_wr;
      case (state)
        ST_AW_ACK: begin
          wr_idx <= idx_of(S_AXI_AWADDR);
          wr_len <= S_AXI_AWLEN;
          wr_cnt <= 8'd0;
          awid_q <= S_AXI_AWID;
        end
        ST_WRITE: begin
          if (wr_hs) begin
            wr_idx <= wr_idx + IDX_ONE;
            wr_cnt <= wr_cnt + 8'd1;
            if (S_AXI_WLAST != (wr_cnt == wr_len)) len_err <= 1'b1;
            if (wr_cnt == wr_len) wr_burst_cnt <= wr_burst_cnt + 16'd1;
          end
        end
        ST_AR_ACK: begin
          S_AXI_RID <= S_AXI_ARID;
          rd_idx    <= idx_of(S_AXI_ARADDR) + IDX_ONE;
          rd_left   <= {1'b0, S_AXI_ARLEN};
        end
        ST_READ: begin
          if (rd_issue) begin
            rd_idx  <= rd_idx + IDX_ONE;
            rd_left <= rd_left - 9'd1;
          end
          if (r_hs && S_AXI_RLAST) rd_burst_cnt <= rd_burst_cnt + 16'd1;
        end
        default: ;
      endcase
      rd_pend_vld  <= rd_issue;
      rd_pend_last <= (state == ST_AR_ACK) ? (S_AXI_ARLEN == 8'd0) : (rd_left == 9'd1);
    end
  end

  axi_rd_skid_buf #(.DATA_W(S_AXI_DATA_WIDTH)) u_skid (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .S_AXI_ARESET(S_AXI_ARESET),
    .in_vld      (rd_pend_vld),
    .in_dat      (rd_q),
    .in_last     (rd_pend_last),
    .in_rdy      (skid_in_rdy),
    .out_vld     (S_AXI_RVALID),
    .out_dat     (S_AXI_RDATA),
    .out_last    (S_AXI_RLAST),
    .out_rdy     (S_AXI_RREADY)
  );

endmodule

// File: tb/tb_vsdma_axi_ram_slave.sv
// Directed bench for vsdma_axi_ram_slave: bursts, backpressure, arbitration, wrap/strobes, errors, reset.
module tb_vsdma_axi_ram_slave;

  localparam int ID_W = 4, ADDR_W = 28, DATA_W = 256, DEPTH = 1024, STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ID_W-1:0]   awid, wid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic              awvalid, awready, wlast, wvalid, wready, arvalid, arready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic              rlast, rvalid, rready, busy, len_err;
  logic [15:0]       wr_burst_cnt, rd_burst_cnt;

  logic [DATA_W-1:0] exp_mem [DEPTH];
  int n_chk = 0, n_pass = 0;

  vsdma_axi_ram_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WID(wid), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .busy(busy), .len_err(len_err),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] mk(input int seed, input int k);
    logic [DATA_W-1:0] r;
    for (int j = 0; j < DATA_W / 32; j++) r[j*32 +: 32] = 32'(seed * 65536 + k * 16 + j);
    return r;
  endfunction

  task automatic axi_write(input logic [ADDR_W-1:0] addr, input int len, input int seed,
                           input int last_at, input logic [STRB_W-1:0] strb0);
    int n, idx;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    awaddr = addr; awlen = 8'(len); awid = 4'(seed); awvalid = 1'b1; n = 0;
    while (!awready && n < 500) begin @(negedge clk); n++; end
    check("aw_handshake", (n < 500), 1);
    @(negedge clk);
    awvalid = 1'b0;
    idx = int'(addr >> 3) % DEPTH;
    for (int k = 0; k <= len; k++) begin
      d = mk(seed, k);
      s = (k == 0) ? strb0 : '1;
      wdata = d; wstrb = s; wvalid = 1'b1;
      wlast = (last_at >= 0) ? (k == last_at) : (k == len);
      n = 0;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("w_beat_timeout", 0, 1);
      for (int b = 0; b < STRB_W; b++) if (s[b]) exp_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      idx = (idx + 1) % DEPTH;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("wready_after_burst", wready, 0);
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int len, input logic [ID_W-1:0] id,
                          input bit rnd);
    int n, idx, beat;
    bit stalled;
    logic [DATA_W-1:0] held;
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1; rready = 1'b0; n = 0;
    while (!arready && n < 500) begin @(negedge clk); n++; end
    check("ar_handshake", (n < 500), 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rvalid_not_early", rvalid, 0);
    @(negedge clk);
    check("rvalid_latency", rvalid, 1);
    idx = int'(addr >> 3) % DEPTH; beat = 0; stalled = 1'b0; held = '0; n = 0;
    while (beat <= len && n < 3000) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) check("rdata_held", {rvalid, rdata[DATA_W-2:0]}, {1'b1, held[DATA_W-2:0]});
      if (rvalid && rready) begin
        check("rdata", rdata, exp_mem[idx]);
        check("rlast", rlast, (beat == len));
        check("rid", rid, id);
        beat++;
        idx = (idx + 1) % DEPTH;
      end
      stalled = rvalid && !rready;
      held = rdata;
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("r_burst_timeout", 0, 1);
    rready = 1'b0;
    check("rvalid_after_last", rvalid, 0);
  endtask

  task automatic first_grant(input bit expect_wr);
    int n = 0;
    while (!(awready || arready) && n < 100) begin @(negedge clk); n++; end
    check("grant_awready", awready, expect_wr);
    check("grant_arready", arready, !expect_wr);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; awid = '0; wid = '0; arid = '0; awaddr = '0; araddr = '0; awlen = '0; arlen = '0;
    awvalid = 0; wvalid = 0; wlast = 0; wdata = '0; wstrb = '0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", {awready, wready, arready, rvalid, rlast, busy, len_err}, 0);
    check("rst_rdata_rid", {rdata, rid}, 0);
    check("rst_counters", {wr_burst_cnt, rd_burst_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 16-beat write then two reads of the same region, second under random RREADY
    axi_write(28'h40, 15, 1, -1, '1);
    check("wr_cnt_1", wr_burst_cnt, 1);
    check("len_err_clean", len_err, 0);
    check("idle_after_wr", busy, 0);
    axi_read(28'h40, 15, 4'd3, 1'b0);
    check("rd_cnt_1", rd_burst_cnt, 1);
    axi_read(28'h40, 15, 4'd3, 1'b1);
    check("rd_cnt_2", rd_burst_cnt, 2);

    // wrap across the top of memory, partial strobes on the first beat
    axi_write(28'h1FF0, 3, 2, -1, '1);
    axi_write(28'h1FF0, 3, 3, -1, 32'h0000_000F);
    check("strobe_1022", dut.mem[1022], {mk(2, 0)[DATA_W-1:32], mk(3, 0)[31:0]});
    check("wrap_idx0", dut.mem[0], mk(3, 2));
    axi_read(28'h1FF0, 3, 4'd9, 1'b1);
    check("wr_cnt_3", wr_burst_cnt, 3);

    // early WLAST: error flagged, burst still runs the full 8 beats
    axi_write(28'h100, 7, 5, 2, '1);
    check("len_err_set", len_err, 1);
    check("wr_cnt_4", wr_burst_cnt, 4);
    axi_read(28'h100, 7, 4'd2, 1'b0);

    // reset in the middle of a stalled read
    araddr = 28'h40; arlen = 8'd15; arid = 4'd5; arvalid = 1'b1; rready = 1'b0; n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("rvalid_stalled", rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rvalid_after_rst", rvalid, 0);
    check("busy_after_rst", busy, 0);
    check("stats_after_rst", {len_err, wr_burst_cnt, rd_burst_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests: write wins first, read wins on the repeat; RAM kept across reset
    fork
      axi_write(28'h200, 3, 6, -1, '1);
      axi_read(28'h40, 15, 4'd6, 1'b0);
      first_grant(1'b1);
    join
    check("conc1_counts", {wr_burst_cnt, rd_burst_cnt}, {16'd1, 16'd1});
    fork
      axi_write(28'h200, 3, 7, -1, '1);
      axi_read(28'h40, 15, 4'd7, 1'b1);
      first_grant(1'b0);
    join
    check("conc2_counts", {wr_burst_cnt, rd_burst_cnt}, {16'd2, 16'd2});
    axi_read(28'h200, 3, 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
